// File: rtl/main_mem_ctrl.sv
// Main-memory controller and word-organised backing store.
// Serves 64-byte line reads through a 16-beat internal burst and 32-bit
// write-through stores, each after a programmable access latency, and
// reports completion with a one-cycle mem_ready pulse.
module main_mem_ctrl #(
  parameter int DEPTH_WORDS   = 4096,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  mem_addr,
  input  logic [31:0]  mem_wdata,
  input  logic         read_req,
  input  logic         write_req,
  output logic [511:0] mem_line_out,
  output logic         mem_ready,
  output logic         busy
);

  localparam int AW   = $clog2(DEPTH_WORDS);
  localparam int MAXL = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CW   = $clog2(MAXL + 1);

  typedef enum logic [2:0] {
    IDLE, R_WAIT, R_BURST, R_DONE, W_WAIT, W_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      beat_q, beat_d;
  logic [AW-1:0]   addr_q, addr_d;    // word index (write) or 16-aligned line base (read)
  logic [31:0]     wdata_q, wdata_d;
  logic [511:0]    line_q, line_d;
  logic            ram_we;

  logic [31:0]     ram_q [DEPTH_WORDS];

  // Only the in-range word-index bits of the address matter; the rest wrap away.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:AW+2], mem_addr[1:0]};

  // Next-state and datapath: accept in IDLE, count latency, burst, pulse ready.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    line_d  = line_q;
    ram_we  = 1'b0;
    case (state_q)
      IDLE: begin
        // Write takes priority; a read arriving with it is dropped.
        if (write_req) begin
          addr_d  = mem_addr[AW+1:2];
          wdata_d = mem_wdata;
          cnt_d   = CW'(WRITE_LATENCY - 1);
          state_d = W_WAIT;
        end else if (read_req) begin
          addr_d  = {mem_addr[AW+1:6], 4'b0000};
          cnt_d   = CW'(READ_LATENCY - 1);
          state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (cnt_q == '0) begin
          beat_d  = 4'd0;
          state_d = R_BURST;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      R_BURST: begin
        // Base is 16-aligned, so base+beat never crosses the wrap point.
        line_d[{beat_q, 5'b00000} +: 32] = ram_q[addr_q + {{(AW-4){1'b0}}, beat_q}];
        beat_d = beat_q + 4'd1;
        if (beat_q == 4'd15) state_d = R_DONE;
      end
      R_DONE: state_d = IDLE;
      W_WAIT: begin
        if (cnt_q == '0) begin
          ram_we  = 1'b1;
          state_d = W_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      W_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and line registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      line_q  <= line_d;
    end
  end

  // Backing store commit; a reset on the commit edge abandons the write.
  always_ff @(posedge clk) begin
    if (rst_n && ram_we) ram_q[addr_q] <= wdata_q;
  end

  assign mem_line_out = line_q;
  assign mem_ready    = (state_q == R_DONE) || (state_q == W_DONE);
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Self-checking bench for main_mem_ctrl: table of requests checked through
// a scoreboard against a word-level memory model, plus hand-written
// sequences for busy-drop, simultaneous requests and mid-operation reset.
module tb_main_mem_ctrl;
  localparam int DW     = 4096;
  localparam int RL     = 4;
  localparam int WL     = 4;
  localparam int RD_LAT = 21;  // READ_LATENCY + 17 with defaults
  localparam int WR_LAT = 5;   // WRITE_LATENCY + 1 with defaults

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  mem_addr = '0;
  logic [31:0]  mem_wdata = '0;
  logic         read_req = 1'b0;
  logic         write_req = 1'b0;
  logic [511:0] mem_line_out;
  logic         mem_ready;
  logic         busy;

  always #5 clk = ~clk;

  main_mem_ctrl #(.DEPTH_WORDS(DW), .READ_LATENCY(RL), .WRITE_LATENCY(WL)) dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .read_req(read_req), .write_req(write_req), .mem_line_out(mem_line_out),
    .mem_ready(mem_ready), .busy(busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mdl [DW];
  bit          kn  [DW];

  typedef struct {
    bit           rd;
    logic [511:0] line;
    logic [511:0] mask;
    int           lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    string       nm;
  } vec_t;
  vec_t tbl[$];

  logic [511:0] last_line = '0;
  logic [511:0] last_mask = '1;

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic exp_t mk_read(input logic [31:0] a);
    exp_t e;
    int unsigned base;
    base = ((a >> 6) * 16) % DW;
    e.rd = 1'b1; e.lat = RD_LAT; e.line = '0; e.mask = '0;
    for (int i = 0; i < 16; i++) begin
      if (kn[base + i]) begin
        e.line[32*i +: 32] = mdl[base + i];
        e.mask[32*i +: 32] = 32'hFFFF_FFFF;
      end
    end
    return e;
  endfunction

  // Drive a one-cycle request and record what the DUT owes us.
  task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int unsigned w;
    @(negedge clk);
    read_req = rd; write_req = wr; mem_addr = a; mem_wdata = d;
    if (wr) begin
      w = (a >> 2) % DW;
      mdl[w] = d; kn[w] = 1'b1;
      e.rd = 1'b0; e.lat = WR_LAT; e.line = last_line; e.mask = last_mask;
    end else begin
      e = mk_read(a);
    end
    sb.push_back(e);
    @(posedge clk); #1;
    read_req = 1'b0; write_req = 1'b0;
    mem_addr = $urandom; mem_wdata = $urandom;
  endtask

  // Wait for the ready pulse (bounded), then compare against the scoreboard.
  task automatic finish_op(input string nm);
    exp_t e;
    int k;
    bit seen, busy_ok;
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 512'd1, 512'd0);
      return;
    end
    e = sb.pop_front();
    k = 1; seen = 1'b0; busy_ok = 1'b1;
    while (k <= 60) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (mem_ready === 1'b1) begin seen = 1'b1; break; end
      @(posedge clk); #1; k++;
    end
    chk({nm, "_latency"}, seen ? 512'(k) : 512'hFFFF, 512'(e.lat));
    chk({nm, "_busy"}, 512'(busy_ok), 512'd1);
    chk({nm, "_line"}, mem_line_out & e.mask, e.line & e.mask);
    if (e.rd) begin last_line = e.line; last_mask = e.mask; end
    @(posedge clk); #1;
    chk({nm, "_idle_after"}, {510'd0, mem_ready, busy}, 512'd0);
  endtask

  initial begin
    int k, nrdy, rdy_k;
    logic [511:0] cap;
    exp_t e;

    for (int i = 0; i < 16; i++)
      tbl.push_back('{0, 1, 32'h40 + 32'(4*i), 32'hA000_0000 + 32'(i), "pre_a"});
    for (int i = 0; i < 16; i++)
      tbl.push_back('{0, 1, 32'h100 + 32'(4*i), 32'hB000_0000 + 32'(i), "pre_b"});
    tbl.push_back('{1, 0, 32'h0000_0047, 32'h0, "rd_0x47"});
    tbl.push_back('{0, 1, 32'h0000_0104, 32'hDEAD_BEEF, "wr_0x104"});
    tbl.push_back('{1, 0, 32'h0000_0100, 32'h0, "rd_0x100"});
    tbl.push_back('{0, 1, 32'h0001_0000, 32'h5555_AAAA, "wr_wrap"});
    tbl.push_back('{1, 0, 32'h0000_0000, 32'h0, "rd_wrap"});
    tbl.push_back('{1, 0, 32'h0040_0100, 32'h0, "rd_hi_alias"});

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 512'(mem_ready), 512'd0);
    chk("reset_busy", 512'(busy), 512'd0);
    chk("reset_line", mem_line_out, 512'd0);
    @(negedge clk); rst_n = 1'b1;

    foreach (tbl[i]) begin
      issue(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d);
      finish_op(tbl[i].nm);
    end

    // Read request while busy is dropped: exactly one ready, first line returned.
    @(negedge clk); read_req = 1'b1; mem_addr = 32'h47;
    @(posedge clk); #1; read_req = 1'b0;
    nrdy = 0; rdy_k = -1; cap = '0;
    for (k = 1; k <= 45; k++) begin
      if (mem_ready === 1'b1) begin nrdy++; rdy_k = k; cap = mem_line_out; end
      if (k == 3) begin read_req = 1'b1; mem_addr = 32'h100; end
      else read_req = 1'b0;
      @(posedge clk); #1;
    end
    chk("busy_drop_count", 512'(nrdy), 512'd1);
    chk("busy_drop_lat", 512'(rdy_k), 512'(RD_LAT));
    chk("busy_drop_w0", 512'(cap[31:0]), 512'h A000_0000);
    chk("busy_drop_w15", 512'(cap[511:480]), 512'h A000_000F);
    e = mk_read(32'h40); last_line = e.line; last_mask = e.mask;

    // Simultaneous read+write: write wins, line untouched, no burst.
    issue(1, 1, 32'h0000_0008, 32'h1234_5678);
    finish_op("rd_wr_same");
    issue(1, 0, 32'h0000_0000, 32'h0);
    finish_op("rd_after_same");

    // Reset during cycle 10 of a read.
    @(negedge clk); read_req = 1'b1; mem_addr = 32'h100;
    @(posedge clk); #1; read_req = 1'b0;
    nrdy = 0;
    for (k = 1; k < 10; k++) begin
      if (mem_ready === 1'b1) nrdy++;
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_rd_busy", 512'(busy), 512'd0);
    chk("rst_rd_ready", 512'(mem_ready), 512'd0);
    chk("rst_rd_line", mem_line_out, 512'd0);
    rst_n = 1'b1;
    for (k = 0; k < 30; k++) begin
      if (mem_ready === 1'b1) nrdy++;
      @(posedge clk); #1;
    end
    chk("rst_rd_no_ready", 512'(nrdy), 512'd0);
    last_line = '0; last_mask = '1;

    // Reset during W_WAIT: target word keeps its old contents.
    @(negedge clk); write_req = 1'b1; mem_addr = 32'h44; mem_wdata = 32'hFFFF_0000;
    @(posedge clk); #1; write_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_wr_busy", 512'(busy), 512'd0);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    issue(1, 0, 32'h0000_0040, 32'h0);
    finish_op("rd_after_wr_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1);
  end
endmodule

// File: doc/main_mem_ctrl.md
Name: main_mem_ctrl

Overview:
- Main-memory controller and backing store directly downstream of the 2-way write-through cache controller.
- Accepts single-cycle line-read requests, returned as one 512-bit / 64-byte block, and single-cycle 32-bit write-through requests.
- Models access latency and signals completion with a one-cycle ready pulse.
- Holds a word-organised RAM and fills a line by a 16-beat internal burst.

Parameters:
- DEPTH_WORDS, 4096: backing store size in 32-bit words; power of two, multiple of 16.
- READ_LATENCY, 4: idle cycles before the read burst starts; must be >= 1.
- WRITE_LATENCY, 4: cycles before a write commits; must be >= 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous and active-low.
- mem_addr  in  32  byte address; sampled only with a request.
- mem_wdata  in  32  write data; sampled with write_req.
- read_req  in  1  line-read request pulse.
- write_req  in  1  word-write request pulse.
- mem_line_out  out  512  fetched line; word i occupies bits [32*i+31 : 32*i].
- mem_ready  out  1  one-cycle completion pulse, for both read and write.
- busy  out  1  high in every state except IDLE.

Behaviour:
- One clock; reset is synchronous and active-low. All state updates happen on posedge clk.
- Reset (rst_n=0 at an edge):
  - state=IDLE, mem_ready=0, busy=0, mem_line_out=0.
  - Counters, beat index and latched address/data are cleared.
  - RAM contents are not reset.
  - Reset mid-operation abandons the operation; no ready is issued and a pending write is not committed.
- States: IDLE, R_WAIT, R_BURST, R_DONE, W_WAIT, W_DONE.
- IDLE:
  - write_req=1: latch word index = mem_addr[31:2] mod DEPTH_WORDS and mem_wdata; load cnt=WRITE_LATENCY-1; go to W_WAIT.
  - Otherwise, read_req=1: latch line base = (mem_addr[31:6]*16) mod DEPTH_WORDS; load cnt=READ_LATENCY-1; go to R_WAIT.
  - Simultaneous read_req and write_req: write wins and the read is dropped.
  - The cache never issues both at once; the bench checks the drop.
- Requests arriving outside IDLE are ignored. There is no queueing; the upstream block holds off while stalled.
- R_WAIT: decrement cnt each cycle; when cnt==0, go to R_BURST with beat=0. R_WAIT lasts exactly READ_LATENCY cycles.
- R_BURST:
  - Each cycle, mem_line_out[32*beat +: 32] <= ram[base+beat]; beat increments.
  - After beat 15 the next state is R_DONE, so the burst lasts exactly 16 cycles.
  - mem_line_out changes during the burst and is not valid until R_DONE.
- R_DONE: mem_ready=1 for one cycle, then IDLE.
- mem_line_out holds its value from R_DONE until the next read's burst begins; writes do not disturb it.
- W_WAIT: decrement cnt; at cnt==0, ram[word] <= wdata and go to W_DONE. W_WAIT lasts exactly WRITE_LATENCY cycles.
- W_DONE: mem_ready=1 for one cycle, then IDLE.
- A read accepted in the cycle after W_DONE observes the written data.
- Latency, counting from the request edge:
  - Read: mem_ready is high in cycle READ_LATENCY+17.
  - Write: mem_ready is high in cycle WRITE_LATENCY+1.
- Address rules:
  - mem_addr[5:0] is ignored for reads; the line is always 64-byte aligned.
  - mem_addr[1:0] is ignored for writes.
  - Addresses beyond the store wrap modulo DEPTH_WORDS; the burst never crosses the wrap because the base is 16-aligned.
- mem_ready is never high in two consecutive cycles, and is never high in IDLE.
- busy is high from the cycle after acceptance through the ready cycle inclusive.
- No X values on any output after reset.

Test Plan:
- Preload ram[16+i]=0xA000_0000+i for i=0..15. Pulse read_req with addr=0x0000_0047 → mem_ready high exactly 21 cycles after the request edge (defaults). mem_line_out[31:0]=0xA000_0000 and [511:480]=0xA000_000F. busy high for 21 cycles.
- write_req with addr=0x0000_0104 and data=0xDEAD_BEEF → mem_ready high 5 cycles later. Then read addr=0x0000_0100 → word 1 of the line = 0xDEAD_BEEF and the other words are unchanged.
- Pulse read_req 3 cycles after an accepted read (while busy) → ignored. Exactly one mem_ready; line matches the first address.
- read_req=write_req=1 in the same cycle (addr=0x0000_0008, data=0x1234_5678) → write performed, ready after 5 cycles. No read burst occurs and mem_line_out is unchanged.
- Wrap: write addr=0x0001_0000 with DEPTH_WORDS=4096 → ram[0] updated. A read at addr=0 returns the data in word 0.
- Assert rst_n=0 during cycle 10 of an outstanding read → next cycle state=IDLE, busy=0, mem_line_out=0, no mem_ready. A write reset during W_WAIT leaves the target RAM word unchanged.
